// File: rtl/drive_pkg.sv
// Shared encodings and constants for the drive-mode arbiter and its UART packet link.
package drive_pkg;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_HANDOVER = 2'd1,
        ST_RUN      = 2'd2
    } drive_state_e;

    localparam logic [1:0] TX_HDR          = 2'b10;
    localparam int         PKT_PLACE_BIT   = 4;
    localparam int         PKT_DESTROY_BIT = 5;

    localparam int         DET_FRONT = 0;
    localparam int         DET_LEFT  = 1;
    localparam int         DET_RIGHT = 2;
    localparam int         DET_BACK  = 3;

    localparam logic [3:0] DET_FAILSAFE = 4'b1111;

    // Bits needed to hold any value in 0..maxVal, never less than one.
    function automatic int cnt_width(input int maxVal);
        return (maxVal > 1) ? $clog2(maxVal + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_pkt_link.sv
// UART packet link: validates and ages the inbound detector byte, and builds,
// change-detects, refreshes and handshakes the outbound moving/beacon byte.
module uart_pkt_link
    import drive_pkg::*;
#(
    parameter int         STALE_CYCLES   = 10_000_000,
    parameter int         REFRESH_CYCLES = 5_000_000,
    parameter logic [3:0] RX_HDR         = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] moving_i,
    input  logic       beaconPlace_i,
    input  logic       beaconDestroy_i,
    input  logic [7:0] rxData_i,
    input  logic       rxValid_i,
    input  logic       txReady_i,
    output logic [7:0] txData_o,
    output logic       txValid_o,
    output logic [3:0] detector_o,
    output logic       detStale_o
);

    localparam int STALE_W = cnt_width(STALE_CYCLES);
    localparam int REFR_W  = cnt_width(REFRESH_CYCLES - 1);

    localparam logic [STALE_W-1:0] STALE_MAX   = STALE_W'(STALE_CYCLES);
    localparam logic [REFR_W-1:0]  REFRESH_MAX = REFR_W'(REFRESH_CYCLES - 1);

    logic [STALE_W-1:0] staleCnt_q, staleCnt_d;
    logic [3:0]         detector_q, detector_d;
    logic               detStale_q, detStale_d;
    logic               rxAccept;

    logic [7:0]         pkt;
    logic [7:0]         txData_q, txData_d;
    logic [7:0]         lastSent_q, lastSent_d;
    logic               txValid_q, txValid_d;
    logic               place_q, place_d;
    logic               destroy_q, destroy_d;
    logic [REFR_W-1:0]  refresh_q, refresh_d;
    logic               handshake;
    logic               refreshDue;

    // Detector ages out to the all-blocked fail-safe value if no good byte arrives.
    always_comb begin
        rxAccept   = rxValid_i && (rxData_i[7:4] == RX_HDR);
        staleCnt_d = staleCnt_q;
        detector_d = detector_q;
        detStale_d = detStale_q;
        if (rxAccept) begin
            staleCnt_d = '0;
            detector_d = rxData_i[3:0];
            detStale_d = 1'b0;
        end else if (staleCnt_q != STALE_MAX) begin
            staleCnt_d = staleCnt_q + STALE_W'(1);
            if (staleCnt_d == STALE_MAX) begin
                detStale_d = 1'b1;
                detector_d = DET_FAILSAFE;
            end
        end
    end

    // A beacon flag only drops when the packet being accepted actually carried it.
    always_comb begin
        pkt        = {TX_HDR, destroy_q, place_q, moving_i};
        handshake  = txValid_q && txReady_i;
        refreshDue = (refresh_q == REFRESH_MAX);
        place_d    = beaconPlace_i   || (place_q   && !(handshake && txData_q[PKT_PLACE_BIT]));
        destroy_d  = beaconDestroy_i || (destroy_q && !(handshake && txData_q[PKT_DESTROY_BIT]));
        txData_d   = txData_q;
        txValid_d  = txValid_q;
        lastSent_d = lastSent_q;
        refresh_d  = refreshDue ? refresh_q : refresh_q + REFR_W'(1);
        if (handshake) begin
            txValid_d  = 1'b0;
            lastSent_d = txData_q;
            refresh_d  = '0;
        end else if (!txValid_q && ((pkt != lastSent_q) || refreshDue)) begin
            txData_d  = pkt;
            txValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staleCnt_q <= '0;
            detector_q <= DET_FAILSAFE;
            detStale_q <= 1'b1;
            txData_q   <= '0;
            txValid_q  <= 1'b0;
            lastSent_q <= '0;
            place_q    <= 1'b0;
            destroy_q  <= 1'b0;
            refresh_q  <= '0;
        end else begin
            staleCnt_q <= staleCnt_d;
            detector_q <= detector_d;
            detStale_q <= detStale_d;
            txData_q   <= txData_d;
            txValid_q  <= txValid_d;
            lastSent_q <= lastSent_d;
            place_q    <= place_d;
            destroy_q  <= destroy_d;
            refresh_q  <= refresh_d;
        end
    end

    assign txData_o   = txData_q;
    assign txValid_o  = txValid_q;
    assign detector_o = detector_q;
    assign detStale_o = detStale_q;

endmodule

// File: rtl/drive_mode_arbiter.sv
// Registered driving-mode arbiter: selects one mode controller, gates it with power
// and forces a stop-and-hold handover whenever the selected mode changes.
module drive_mode_arbiter
    import drive_pkg::*;
#(
    parameter int         N_MODES        = 4,
    parameter int         MODE_W         = 2,
    parameter int         STATE_W        = 2,
    parameter int         MOVE_W         = 4,
    parameter int         HOLD_CYCLES    = 50_000_000,
    parameter int         STALE_CYCLES   = 10_000_000,
    parameter int         REFRESH_CYCLES = 5_000_000,
    parameter logic [3:0] RX_HDR         = 4'h0
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       power,
    input  logic [MODE_W-1:0]          mode_sel,
    input  logic [N_MODES*STATE_W-1:0] mode_state,
    input  logic [N_MODES*MOVE_W-1:0]  mode_moving,
    input  logic                       beacon_place,
    input  logic                       beacon_destroy,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [STATE_W-1:0]         state_out,
    output logic [MOVE_W-1:0]          moving_out,
    output logic [MODE_W-1:0]          cur_mode,
    output logic                       handover_busy,
    output logic [3:0]                 detector,
    output logic                       det_stale
);

    localparam int                HOLD_W   = cnt_width(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    drive_state_e         state_q;
    logic [MODE_W-1:0]    target_q;
    logic [MODE_W-1:0]    curMode_q;
    logic [HOLD_W-1:0]    hold_q;
    logic [STATE_W-1:0]   stateOut_q;
    logic [MOVE_W-1:0]    movingOut_q;
    logic                 busy_q;
    logic [STATE_W-1:0]   selState;
    logic [MOVE_W-1:0]    selMoving;
    logic                 targetValid;

    always_comb begin
        selState    = '0;
        selMoving   = '0;
        targetValid = int'(target_q) < N_MODES;
        for (int i = 0; i < N_MODES; i++) begin
            if (curMode_q == MODE_W'(i)) begin
                selState  = mode_state[i*STATE_W +: STATE_W];
                selMoving = mode_moving[i*MOVE_W +: MOVE_W];
            end
        end
    end

    // Any request change during the hold restarts the full stop period.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            target_q    <= '0;
            curMode_q   <= '0;
            hold_q      <= '0;
            stateOut_q  <= '0;
            movingOut_q <= '0;
            busy_q      <= 1'b0;
        end else if (!power) begin
            state_q     <= ST_OFF;
            curMode_q   <= '0;
            stateOut_q  <= '0;
            movingOut_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    target_q <= mode_sel;
                    hold_q   <= HOLD_MAX;
                    busy_q   <= 1'b1;
                    state_q  <= ST_HANDOVER;
                end
                ST_HANDOVER: begin
                    if (mode_sel != target_q) begin
                        target_q <= mode_sel;
                        hold_q   <= HOLD_MAX;
                    end else if (hold_q != '0) begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end else if (targetValid) begin
                        curMode_q <= target_q;
                        busy_q    <= 1'b0;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (mode_sel != curMode_q) begin
                        target_q    <= mode_sel;
                        hold_q      <= HOLD_MAX;
                        stateOut_q  <= '0;
                        movingOut_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_HANDOVER;
                    end else begin
                        stateOut_q  <= selState;
                        movingOut_q <= selMoving;
                    end
                end
                default: state_q <= ST_OFF;
            endcase
        end
    end

    assign state_out     = stateOut_q;
    assign moving_out    = movingOut_q;
    assign cur_mode      = curMode_q;
    assign handover_busy = busy_q;

    uart_pkt_link #(
        .STALE_CYCLES  (STALE_CYCLES),
        .REFRESH_CYCLES(REFRESH_CYCLES),
        .RX_HDR        (RX_HDR)
    ) u_link (
        .clk            (sys_clk),
        .rst_n          (rst_n),
        .moving_i       (movingOut_q),
        .beaconPlace_i  (beacon_place),
        .beaconDestroy_i(beacon_destroy),
        .rxData_i       (rx_data),
        .rxValid_i      (rx_valid),
        .txReady_i      (tx_ready),
        .txData_o       (tx_data),
        .txValid_o      (tx_valid),
        .detector_o     (detector),
        .detStale_o     (det_stale)
    );

endmodule

// File: doc/drive_mode_arbiter.md
Name: drive_mode_arbiter

Overview:
- Registered successor to the combinational mode mux in the vehicle top level.
- Selects one of N_MODES driving-mode controllers (manual, semi-auto, auto, …) and gates its outputs with power.
- Enforces a stop-and-hold handover whenever the selected mode changes.
- Owns both UART link packets: validates and ages the inbound detector byte, and builds, change-detects and handshakes the outbound moving/beacon byte.

Parameters:
N_MODES, 4, number of mode controllers (≥2)
MODE_W, 2, width of mode_sel (2**MODE_W ≥ N_MODES)
STATE_W, 2, per-mode state width
MOVE_W, 4, per-mode moving-state width (fixed 4 for the UART packet)
HOLD_CYCLES, 50_000_000, handover stop duration in sys_clk cycles (≥1)
STALE_CYCLES, 10_000_000, cycles without a valid detector byte before the data is treated as stale
REFRESH_CYCLES, 5_000_000, maximum interval between tx packets with unchanged content
RX_HDR, 4'h0, required upper nibble of an inbound detector byte

Ports:
sys_clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous, active-low reset
power  in  1  engine power level
mode_sel  in  MODE_W  requested mode (global_state)
mode_state  in  N_MODES*STATE_W  flattened per-mode next state; mode i at [i*STATE_W +: STATE_W]
mode_moving  in  N_MODES*MOVE_W  flattened per-mode next moving state
beacon_place  in  1  one-cycle request to place a beacon
beacon_destroy  in  1  one-cycle request to destroy a beacon
rx_data  in  8  byte from the UART receiver
rx_valid  in  1  rx_data valid strobe, one cycle
tx_data  out  8  outbound packet
tx_valid  out  1  packet-valid flag, held until accepted
tx_ready  in  1  UART transmitter ready
state_out  out  STATE_W  arbitrated state
moving_out  out  MOVE_W  arbitrated moving state
cur_mode  out  MODE_W  mode currently in control
handover_busy  out  1  high while in HANDOVER
detector  out  4  {back,right,left,front}
det_stale  out  1  detector data is stale

Behaviour:
- Reset (async, rst_n=0) clears everything:
  - FSM to OFF.
  - state_out, moving_out, cur_mode, tx_data, tx_valid, handover_busy all 0.
  - detector=4'b1111, det_stale=1.
  - Counters 0, beacon flags 0.
- FSM states OFF, HANDOVER, RUN. power=0 forces OFF on the next edge from any state.
- OFF:
  - Outputs are zero.
  - When power=1: target<=mode_sel, counter<=HOLD_CYCLES-1, go to HANDOVER.
- HANDOVER:
  - handover_busy=1; state_out=0, moving_out=0.
  - Counter decrements each cycle.
  - If mode_sel≠target: target<=mode_sel and the counter reloads.
  - When counter=0 and target<N_MODES: cur_mode<=target, go to RUN.
  - An invalid target (≥N_MODES) holds HANDOVER indefinitely.
- RUN:
  - state_out/moving_out are registered from slice cur_mode: one-cycle latency.
  - If mode_sel≠cur_mode: go to HANDOVER and zero outputs on the same edge.
- Detector path:
  - A byte is accepted when rx_valid=1 and rx_data[7:4]==RX_HDR. Then detector<=rx_data[3:0], det_stale<=0, stale counter<=0.
  - Bytes with a wrong header are dropped; the stale counter keeps running.
  - The stale counter saturates at STALE_CYCLES. On reaching it: det_stale=1 and detector forced to 4'b1111 (all blocked, fail-safe).
- Beacon flags:
  - Sticky; set by their input pulse.
  - Cleared on the handshake (tx_valid&tx_ready) of the packet that carried them.
  - A pulse arriving in the same cycle as that handshake keeps the flag set.
- Tx packet content: pkt = {2'b10, destroy_flag, place_flag, moving_out}.
- Tx launch:
  - Condition: tx_valid=0 and either pkt≠last_sent or the refresh counter reaches REFRESH_CYCLES-1.
  - Action: tx_data<=pkt, tx_valid<=1.
  - tx_data is stable while tx_valid=1.
  - On tx_ready: tx_valid<=0, last_sent<=tx_data, refresh counter<=0.
  - A new launch waits at least one cycle after a handshake.
- Changes of pkt while a packet is pending are not lost: they are compared against last_sent after the handshake.
- The refresh counter runs in every FSM state, so the OFF packet (moving=0) is still refreshed.

Decomposition:
- Shared package drive_pkg holds:
  - State encodings ST_OFF/ST_HANDOVER/ST_RUN.
  - Packet header constant 2'b10.
  - Detector bit indices.
  - Fail-safe detector value 4'b1111.
- Natural sub-module: uart_pkt_link, containing the detector validation/stale logic and the tx build/handshake/refresh logic.
- The FSM and output mux remain in drive_mode_arbiter.

Test Plan:
- Reset then power=1, mode_sel=1, HOLD_CYCLES=4 → handover_busy for 4 cycles. Next edge: state_out/moving_out equal slice 1 one cycle after the inputs change; cur_mode=1.
- In RUN mode 1, switch mode_sel to 2 at cycle 2 of a handover to mode 0 → counter reloads. RUN mode 2 occurs exactly HOLD_CYCLES cycles after the last change; moving_out=0 throughout.
- mode_sel=3 with N_MODES=3 → stays in HANDOVER and outputs 0. power=0 → OFF next edge.
- rx byte 8'h05 with RX_HDR=0 → detector=4'b0101, det_stale=0. Byte 8'h35 → ignored. STALE_CYCLES=8 with no bytes → detector=4'b1111, det_stale=1.
- moving_out changes to 4'b1000 with tx_ready=0 for 5 cycles → tx_valid held and tx_data=8'h88 stable. A beacon_place pulse during the wait appears in the next packet (8'h98) and is cleared after its handshake.
- No content change, REFRESH_CYCLES=16, tx_ready=1 → a packet is emitted every 17 cycles with identical tx_data.
